// File: rtl/uart_echo_pkg.sv
// Shared types and constants for the UART echo responder.
// FSM state enums, ASCII case-conversion bounds and default parameter values.
package uart_echo_pkg;

    localparam int DEF_FIFO_DEPTH   = 4;
    localparam int DEF_LOAD_TIMEOUT = 1023;

    localparam logic [7:0] ASCII_LOWER_A = 8'h61;
    localparam logic [7:0] ASCII_LOWER_Z = 8'h7A;
    localparam logic [7:0] UPCASE_MASK   = 8'hDF;

    typedef enum logic {
        R_IDLE   = 1'b0,
        R_UNLOAD = 1'b1
    } rx_state_t;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_LOAD = 2'd1,
        T_WAIT = 2'd2
    } tx_state_t;

    // Lower-case ASCII letters lose bit 5; everything else passes through.
    function automatic logic [7:0] upcase_byte(input logic [7:0] b);
        if (b >= ASCII_LOWER_A && b <= ASCII_LOWER_Z) begin
            return b & UPCASE_MASK;
        end
        return b;
    endfunction

endpackage

// File: rtl/uart_echo_fifo.sv
// Byte FIFO for the echo path: power-of-two depth, wrapping pointers,
// explicit occupancy counter, read data taken straight from the head slot.
import uart_echo_pkg::*;

module uart_echo_fifo #(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic                        pop,
    input  logic [7:0]                  wdata,
    output logic [7:0]                  rdata,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = PTR_W + 1;

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CW-1:0]    r_count;

    // Storage write; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; simultaneous push/pop keeps the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rdata = r_mem[r_rd_ptr];
    assign full  = (r_count == CW'(FIFO_DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule

// File: rtl/uart_echo_responder.sv
// UART echo responder: unloads received bytes from an attached uart into a
// small FIFO and loads them back into the uart transmitter in arrival order.
// Optional macro UART_ECHO_UPCASE_EN converts ASCII a..z to A..Z on entry.
import uart_echo_pkg::*;

module uart_echo_responder #(
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int LOAD_TIMEOUT = DEF_LOAD_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        rx_empty,
    input  logic [7:0]                  rx_data,
    output logic                        uld_rx_data,
    input  logic                        tx_empty,
    output logic                        ld_tx_data,
    output logic [7:0]                  tx_data,
    input  logic                        echo_en,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        rx_stall,
    output logic                        tx_err
);

    localparam int CNT_W = $clog2(LOAD_TIMEOUT + 1);

    logic [1:0]                  r_rst_sync;
    logic                        w_run;
    rx_state_t                   r_rx_state, w_rx_state_next;
    tx_state_t                   r_tx_state, w_tx_state_next;
    logic [7:0]                  r_tx_data, w_tx_data_next;
    logic                        r_ld_tx_data, w_ld_tx_data_next;
    logic [CNT_W-1:0]            r_tmo_cnt, w_tmo_cnt_next;
    logic                        r_rx_stall, w_rx_stall_next;
    logic                        r_tx_err, w_tx_err_next;
    logic                        w_push, w_pop, w_full, w_empty;
    logic [7:0]                  w_wdata, w_rdata;
    logic [$clog2(FIFO_DEPTH):0] w_count;

`ifdef UART_ECHO_UPCASE_EN
    assign w_wdata = upcase_byte(rx_data);
`else
    assign w_wdata = rx_data;
`endif

    uart_echo_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (w_push),
        .pop  (w_pop),
        .wdata(w_wdata),
        .rdata(w_rdata),
        .full (w_full),
        .empty(w_empty),
        .count(w_count)
    );

    // Reset asserts immediately but releases through two flops; FSMs act only once it is through.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_run = r_rst_sync[1];

    // RX handshake: request an unload only when there is room, capture once the uart reports empty.
    always_comb begin
        w_rx_state_next = r_rx_state;
        w_rx_stall_next = r_rx_stall;
        w_push          = 1'b0;
        if (w_run) begin
            case (r_rx_state)
                R_IDLE: begin
                    if (!rx_empty && echo_en) begin
                        if (w_full) begin
                            w_rx_stall_next = 1'b1;
                        end else begin
                            w_rx_state_next = R_UNLOAD;
                        end
                    end
                end
                R_UNLOAD: begin
                    if (rx_empty) begin
                        w_push          = 1'b1;
                        w_rx_state_next = R_IDLE;
                    end
                end
                default: w_rx_state_next = R_IDLE;
            endcase
        end
    end

    // TX handshake: pop into the output register, hold the load request until the uart takes it or time runs out.
    always_comb begin
        w_tx_state_next   = r_tx_state;
        w_tx_data_next    = r_tx_data;
        w_ld_tx_data_next = r_ld_tx_data;
        w_tmo_cnt_next    = r_tmo_cnt;
        w_tx_err_next     = r_tx_err;
        w_pop             = 1'b0;
        if (w_run) begin
            case (r_tx_state)
                T_IDLE: begin
                    if (!w_empty && tx_empty) begin
                        w_pop             = 1'b1;
                        w_tx_data_next    = w_rdata;
                        w_ld_tx_data_next = 1'b1;
                        w_tmo_cnt_next    = '0;
                        w_tx_state_next   = T_LOAD;
                    end
                end
                T_LOAD: begin
                    if (!tx_empty) begin
                        w_ld_tx_data_next = 1'b0;
                        w_tx_state_next   = T_WAIT;
                    end else if (r_tmo_cnt == CNT_W'(LOAD_TIMEOUT - 1)) begin
                        // The load request has been high for LOAD_TIMEOUT cycles: drop the byte.
                        w_ld_tx_data_next = 1'b0;
                        w_tx_err_next     = 1'b1;
                        w_tx_state_next   = T_IDLE;
                    end else begin
                        w_tmo_cnt_next = r_tmo_cnt + CNT_W'(1);
                    end
                end
                T_WAIT: begin
                    if (tx_empty) begin
                        w_tx_state_next = T_IDLE;
                    end
                end
                default: begin
                    w_ld_tx_data_next = 1'b0;
                    w_tx_state_next   = T_IDLE;
                end
            endcase
        end
    end

    // State and output registers for both handshakes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_state   <= R_IDLE;
            r_tx_state   <= T_IDLE;
            r_tx_data    <= 8'h00;
            r_ld_tx_data <= 1'b0;
            r_tmo_cnt    <= '0;
            r_rx_stall   <= 1'b0;
            r_tx_err     <= 1'b0;
        end else begin
            r_rx_state   <= w_rx_state_next;
            r_tx_state   <= w_tx_state_next;
            r_tx_data    <= w_tx_data_next;
            r_ld_tx_data <= w_ld_tx_data_next;
            r_tmo_cnt    <= w_tmo_cnt_next;
            r_rx_stall   <= w_rx_stall_next;
            r_tx_err     <= w_tx_err_next;
        end
    end

    assign uld_rx_data = (r_rx_state == R_UNLOAD);
    assign ld_tx_data  = r_ld_tx_data;
    assign tx_data     = r_tx_data;
    assign fifo_count  = w_count;
    assign rx_stall    = r_rx_stall;
    assign tx_err      = r_tx_err;

endmodule

// File: tb/tb_uart_echo_responder.sv
// Testbench for uart_echo_responder with a behavioural uart model on both
// handshakes and a queue-based scoreboard of expected echoes.
module tb_uart_echo_responder;

    localparam int DEPTH = 4;
    localparam int TMO   = 1023;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rx_empty = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          uld_rx_data;
    logic          tx_empty = 1'b1;
    logic          ld_tx_data;
    logic [7:0]    tx_data;
    logic          echo_en = 1'b1;
    logic [CW-1:0] fifo_count;
    logic          rx_stall;
    logic          tx_err;

    int tests = 0;
    int fails = 0;

    logic [7:0] rx_q[$];
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    bit         tx_block = 1'b0;
    bit         tx_stuck = 1'b0;
    int         tx_len = 4;
    int         tx_busy = 0;

    uart_echo_responder #(
        .FIFO_DEPTH  (DEPTH),
        .LOAD_TIMEOUT(TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_empty   (rx_empty),
        .rx_data    (rx_data),
        .uld_rx_data(uld_rx_data),
        .tx_empty   (tx_empty),
        .ld_tx_data (ld_tx_data),
        .tx_data    (tx_data),
        .echo_en    (echo_en),
        .fifo_count (fifo_count),
        .rx_stall   (rx_stall),
        .tx_err     (tx_err)
    );

    always #5 clk = ~clk;

    // Attached uart: rx_q holds bytes waiting in the receiver, got_q records bytes the transmitter accepted.
    always @(posedge clk) begin : uart_model
        logic [7:0] b;
        if (uld_rx_data && !rx_empty && rx_q.size() > 0) begin
            b = rx_q.pop_front();
            rx_data  <= b;
            rx_empty <= 1'b1;
        end else if (rx_empty && !uld_rx_data && rx_q.size() > 0) begin
            rx_empty <= 1'b0;
        end
        if (tx_stuck) begin
            tx_empty <= 1'b1;
        end else if (tx_block) begin
            tx_empty <= 1'b0;
        end else if (tx_busy > 0) begin
            tx_busy <= tx_busy - 1;
            if (tx_busy == 1) tx_empty <= 1'b1;
        end else if (ld_tx_data && tx_empty) begin
            got_q.push_back(tx_data);
            tx_empty <= 1'b0;
            tx_busy  <= tx_len;
        end else begin
            tx_empty <= 1'b1;
        end
    end

    // Expected echo of one byte: ASCII letters shift down by 0x20 when conversion is built in.
    function automatic logic [7:0] echo_of(input logic [7:0] b);
`ifdef UART_ECHO_UPCASE_EN
        if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
`endif
        return b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_q.push_back(b);
        exp_q.push_back(echo_of(b));
    endtask

    task automatic send_lost(input logic [7:0] b);
        rx_q.push_back(b);
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        logic [7:0] g, e;
        n = 0;
        while (got_q.size() < exp_q.size() && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            $display("[TB] %s echo 0x%02h model 0x%02h", tag, g, e);
            check({tag, "_byte"}, 32'(g), 32'(e));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n;
        int hi;
        bit seen;
        logic [7:0] b1, b2, b3;

        // Reset values, with a byte already waiting in the uart.
        #2 reset = 1'b0;
        send(8'h55);
        repeat (3) @(negedge clk);
        check("rst_uld", 32'(uld_rx_data), 32'd0);
        check("rst_ld", 32'(ld_tx_data), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_rx_stall", 32'(rx_stall), 32'd0);
        check("rst_tx_err", 32'(tx_err), 32'd0);

        // Release: nothing may happen on the first two edges.
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("release_no_early_uld", 32'(uld_rx_data), 32'd0);

        // Single byte loopback.
        drain("single", 200);
        check("single_fifo_count", 32'(fifo_count), 32'd0);
        check("single_rx_stall", 32'(rx_stall), 32'd0);
        check("single_tx_err", 32'(tx_err), 32'd0);

        // Back-to-back trio including a lower-case letter.
        send(8'h41);
        send(8'h7D);
        send(8'h61);
        drain("trio", 400);

        // Randomised bytes, gaps and transmitter busy times.
        for (int i = 0; i < 20; i++) begin
            logic [7:0] b;
            repeat ($urandom_range(0, 6)) @(negedge clk);
            tx_len = $urandom_range(1, 12);
            if ($urandom_range(0, 3) == 0) b = 8'($urandom_range(8'h61, 8'h7A));
            else b = 8'($urandom);
            send(b);
        end
        drain("rand", 4000);

        // echo_en low blocks new unloads; raising it starts one within 2 cycles.
        echo_en = 1'b0;
        send(8'h3C);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (uld_rx_data) seen = 1'b1;
        end
        check("echo_dis_uld", 32'(seen), 32'd0);
        echo_en = 1'b1;
        n = 0;
        while (!uld_rx_data && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("echo_en_latency_ok", 32'(n >= 1 && n <= 2), 32'd1);
        drain("echo_en", 200);

        // Transmitter blocked: four bytes fill the buffer, the fifth stays in the uart.
        tx_block = 1'b1;
        tx_len = 3;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) send(8'(8'h30 + i));
        n = 0;
        while (!(fifo_count == CW'(DEPTH) && rx_stall) && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("full_fifo_count", 32'(fifo_count), 32'(DEPTH));
        check("full_rx_stall", 32'(rx_stall), 32'd1);
        check("full_fifth_waiting", 32'(rx_empty), 32'd0);
        check("full_uld_idle", 32'(uld_rx_data), 32'd0);
        tx_block = 1'b0;
        drain("full", 600);
        check("full_rx_stall_sticky", 32'(rx_stall), 32'd1);
        check("full_drained_count", 32'(fifo_count), 32'd0);

        // Transmitter never takes the byte: load request times out after LOAD_TIMEOUT cycles.
        tx_stuck = 1'b1;
        @(negedge clk);
        send_lost(8'h33);
        n = 0;
        while (!ld_tx_data && n < 50) begin
            @(negedge clk);
            n++;
        end
        hi = 0;
        while (ld_tx_data && hi < 3000) begin
            hi++;
            @(negedge clk);
        end
        check("tmo_ld_cycles", 32'(hi), 32'(TMO));
        check("tmo_tx_err", 32'(tx_err), 32'd1);
        check("tmo_fifo_count", 32'(fifo_count), 32'd0);
        tx_stuck = 1'b0;
        send(8'h44);
        drain("after_tmo", 300);
        check("tmo_tx_err_sticky", 32'(tx_err), 32'd1);

        // Reset during an unload: buffered byte lost, the byte still in the uart echoes later.
        tx_block = 1'b1;
        repeat (2) @(negedge clk);
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        b3 = 8'($urandom);
        send_lost(b1);
        n = 0;
        while (fifo_count != CW'(1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        send(b2);
        n = 0;
        while (!uld_rx_data && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("mid_uld_seen", 32'(uld_rx_data), 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_uld", 32'(uld_rx_data), 32'd0);
        check("mid_rst_ld", 32'(ld_tx_data), 32'd0);
        check("mid_rst_tx_data", 32'(tx_data), 32'h00);
        check("mid_rst_fifo_count", 32'(fifo_count), 32'd0);
        check("mid_rst_rx_stall", 32'(rx_stall), 32'd0);
        check("mid_rst_tx_err", 32'(tx_err), 32'd0);
        tx_block = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        drain("post_rst", 300);
        send(b3);
        drain("post_rst_next", 300);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_echo_responder.md
UART_ECHO_RESPONDER -- requirements
Module: uart_echo_responder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, echo-buffer depth in bytes (power of two, 2..16).
REQ-002 Parameter LOAD_TIMEOUT, default 1023, max clk cycles ld_tx_data may stay high without tx_empty falling.
REQ-003 clk  input  1  single clock; the attached uart's txclk and rxclk are driven from this same clock.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 rx_empty  input  1  uart flag; low means a received byte is waiting.
REQ-006 rx_data  input  8  uart received byte; valid once rx_empty returns high after unload.
REQ-007 uld_rx_data  output  1  unload request to the uart.
REQ-008 tx_empty  input  1  uart flag; high means the transmitter can accept a byte.
REQ-009 ld_tx_data  output  1  load request to the uart.
REQ-010 tx_data  output  8  byte presented to the uart; registered.
REQ-011 echo_en  input  1  high enables accepting new received bytes.
REQ-012 fifo_count  output  $clog2(FIFO_DEPTH)+1  current buffer occupancy.
REQ-013 rx_stall  output  1  sticky; a byte was waiting while the buffer was full.
REQ-014 tx_err  output  1  sticky; LOAD_TIMEOUT expired.

Function
REQ-015 RX FSM states: R_IDLE, R_UNLOAD.
- R_IDLE -> R_UNLOAD when rx_empty=0, echo_en=1 and buffer not full.
- uld_rx_data=1 throughout R_UNLOAD.
REQ-016 In R_UNLOAD, on the first cycle rx_empty=1:
- push rx_data into the buffer;
- drop uld_rx_data on the next edge;
- return to R_IDLE.
- Minimum unload latency: 2 cycles.
REQ-017 When rx_empty=0, echo_en=1 and the buffer is full, the RX FSM stays in R_IDLE and rx_stall is set; the byte is left in the uart.
REQ-018 echo_en falling during R_UNLOAD does not abort the handshake; only new unloads are blocked.
REQ-019 TX FSM states: T_IDLE, T_LOAD, T_WAIT.
- T_IDLE -> T_LOAD when the buffer is non-empty and tx_empty=1; pop the head into tx_data and set ld_tx_data=1 on the same edge.
- T_LOAD -> T_WAIT when tx_empty=0; clear ld_tx_data.
- T_WAIT -> T_IDLE when tx_empty=1.
REQ-020 In T_LOAD, a cycle counter reaching LOAD_TIMEOUT causes:
- ld_tx_data cleared;
- tx_err set;
- return to T_IDLE;
- the popped byte is discarded.
REQ-021 A push and a pop in the same cycle are both performed; fifo_count is unchanged.
- Push is never attempted when full; pop is never attempted when empty.
- Pointers wrap modulo FIFO_DEPTH.
REQ-022 Bytes are echoed in arrival order, with no loss while the buffer is not full.
REQ-023 rx_stall and tx_err clear only on reset.

Reset
REQ-024 While reset=0, asynchronously:
- uld_rx_data=0, ld_tx_data=0, tx_data=8'h00;
- fifo_count=0, rx_stall=0, tx_err=0;
- FSMs in R_IDLE / T_IDLE; buffer pointers zeroed.
REQ-025 Reset asserted mid-handshake abandons the handshake; any buffered byte is lost.
REQ-026 Reset deassertion is synchronised internally (two-flop release); first FSM action is no earlier than the second clk edge after release.

Configuration
REQ-027 Macro UART_ECHO_UPCASE_EN.
- Defined: a byte in 8'h61..8'h7A has bit 5 cleared at push (ASCII lower-to-upper); all other bytes pass unchanged.
- Undefined: all bytes are echoed unmodified and no conversion logic exists.

Structure
REQ-028 Package uart_echo_pkg holds:
- rx_state_t and tx_state_t enums;
- the ASCII bounds 8'h61 and 8'h7A and UPCASE_MASK 8'hDF;
- default FIFO_DEPTH and LOAD_TIMEOUT constants.
REQ-029 Sub-module uart_echo_fifo: synchronous FIFO with push, pop, wdata, rdata, full, empty and count ports, parameterised by FIFO_DEPTH.

Verification
REQ-030 Loopback with a uart model, send 8'h55 -> 8'h55 is echoed once; fifo_count returns to 0; rx_stall=0 and tx_err=0.
REQ-031 Send 8'h41, 8'h7D, 8'h61 back-to-back -> echoed in that order.
- With UART_ECHO_UPCASE_EN: 8'h41, 8'h7D, 8'h41.
- Without the macro: 8'h41, 8'h7D, 8'h61.
REQ-032 Hold tx_empty=0 and deliver 5 bytes with FIFO_DEPTH=4 -> fifo_count=4; rx_stall=1; the 5th byte stays in the uart until tx_empty is released.
REQ-033 Hold tx_empty=1 permanently after a load -> ld_tx_data drops after exactly 1023 cycles; tx_err=1; the next byte is still processed.
REQ-034 Assert reset while uld_rx_data=1 -> all outputs zero within the same cycle; after release the next byte is echoed normally.
REQ-035 echo_en=0 with rx_empty=0 -> uld_rx_data stays 0; raising echo_en -> unload begins within 2 cycles.
